nx_event_counter_array_mp: RTL and testbench

// Multi-port event counter array: N_PORTS independent count strobes update N_COUNTERS wide counters every cycle.

---
 rtl/nx_event_counter_array_mp_if.sv | 31 +++
 rtl/nx_event_counter_array_mp.sv | 106 ++++++++++
 tb/tb_nx_event_counter_array_mp.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_event_counter_array_mp_if.sv
// Register-bus and count-port bundle for the multi-port event counter array.
// The master drives reads, writes and count strobes; the slave answers with rd_ack.
interface nx_event_counter_array_mp_if #(
    parameter int unsigned N_ADDR_BITS     = 16,
    parameter int unsigned N_REG_BITS      = 32,
    parameter int unsigned N_PORTS         = 2,
    parameter int unsigned N_COUNT_BY_BITS = 4,
    parameter int unsigned N_ID_BITS       = 3
);
    logic [N_ADDR_BITS-1:0]                      reg_addr;
    logic                                        counter_config;
    logic                                        rd_stb;
    logic                                        wr_stb;
    logic [N_REG_BITS-1:0]                       reg_data;
    logic                                        rd_ack;
    logic [N_PORTS-1:0]                          count_stb;
    logic [N_PORTS-1:0][N_COUNT_BY_BITS-1:0]     count_by;
    logic [N_PORTS-1:0][N_ID_BITS-1:0]           count_id;

    modport master (
        output reg_addr, counter_config, rd_stb, wr_stb, reg_data,
        output count_stb, count_by, count_id,
        input  rd_ack
    );

    modport slave (
        input  reg_addr, counter_config, rd_stb, wr_stb, reg_data,
        input  count_stb, count_by, count_id,
        output rd_ack
    );
endinterface

// File: rtl/nx_event_counter_array_mp.sv
// Multi-port event counter array: per-cycle summed increments, saturate/wrap,
// sticky overflow, per-counter or global snapshot reads and write-to-subtract.
module nx_event_counter_array_mp #(
    parameter int unsigned GLBL_RD_ADDRESS = 0,
    parameter int unsigned BASE_ADDRESS    = 0,
    parameter int unsigned ALIGNMENT       = 2,
    parameter int unsigned N_ADDR_BITS     = 16,
    parameter int unsigned N_REG_BITS      = 32,
    parameter int unsigned N_COUNTERS      = 8,
    parameter int unsigned N_PORTS         = 2,
    parameter int unsigned N_COUNT_BY_BITS = 4,
    parameter int unsigned N_COUNTER_BITS  = 64,
    parameter int unsigned SATURATE        = 1,
    parameter int unsigned CLR_ON_RD       = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nx_event_counter_array_mp_if.slave bus,
    output logic [N_COUNTER_BITS-1:0] counter_a [N_COUNTERS],
    output logic [N_COUNTERS-1:0]     ovf_a
);
    localparam int unsigned ID_W  = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;
    localparam int unsigned INC_W = N_COUNT_BY_BITS + $clog2(N_PORTS);
    localparam int unsigned CMP_W = (N_COUNTER_BITS > N_REG_BITS) ? N_COUNTER_BITS : N_REG_BITS;
    // Address math is done wide enough that BASE + span can never wrap.
    localparam int unsigned AW    = ((N_ADDR_BITS > 32) ? N_ADDR_BITS : 32) + 2;

    localparam logic [AW-1:0] BASE_W = AW'(BASE_ADDRESS);
    localparam logic [AW-1:0] END_W  = AW'(BASE_ADDRESS) + (AW'(N_COUNTERS) << ALIGNMENT);
    localparam logic [AW-1:0] GLBL_W = AW'(GLBL_RD_ADDRESS);

    logic [N_COUNTER_BITS-1:0] cnt   [N_COUNTERS];
    logic [INC_W-1:0]          inc   [N_COUNTERS];
    logic [N_COUNTER_BITS:0]   sum   [N_COUNTERS];
    logic [N_COUNTER_BITS-1:0] nxt   [N_COUNTERS];
    logic [N_COUNTER_BITS-1:0] wres  [N_COUNTERS];
    logic [N_COUNTERS-1:0]     carry;
    logic [N_COUNTERS-1:0]     borrow;
    logic [N_COUNTERS-1:0]     rd_hit;
    logic [N_COUNTERS-1:0]     wr_hit;

    logic [AW-1:0] addr_w;
    logic [AW-1:0] idx_w;
    logic          selected;
    logic          rd_valid;
    logic          wr_valid;

    always_comb begin
        addr_w   = AW'(bus.reg_addr);
        selected = (addr_w >= BASE_W) && (addr_w < END_W);
        idx_w    = (addr_w - BASE_W) >> ALIGNMENT;
        rd_valid = bus.counter_config ? (bus.rd_stb && (addr_w == GLBL_W))
                                      : (bus.rd_stb && selected);
        wr_valid = bus.wr_stb && selected && !rd_valid;
    end

    always_comb begin
        for (int i = 0; i < N_COUNTERS; i++) begin
            inc[i] = '0;
            // Out-of-range ids never match any i, so they drop out here.
            for (int p = 0; p < N_PORTS; p++) begin
                if (bus.count_stb[p] && (bus.count_id[p] == ID_W'(i)))
                    inc[i] = inc[i] + INC_W'(bus.count_by[p]);
            end
            sum[i]    = {1'b0, cnt[i]} + (N_COUNTER_BITS+1)'(inc[i]);
            carry[i]  = sum[i][N_COUNTER_BITS];
            nxt[i]    = (SATURATE != 0 && carry[i]) ? '1 : sum[i][N_COUNTER_BITS-1:0];
            borrow[i] = CMP_W'(nxt[i]) < CMP_W'(bus.reg_data);
            wres[i]   = (SATURATE != 0 && borrow[i]) ? '0
                                                     : nxt[i] - N_COUNTER_BITS'(bus.reg_data);
            rd_hit[i] = rd_valid && (bus.counter_config || (idx_w == AW'(i)));
            wr_hit[i] = wr_valid && (idx_w == AW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_COUNTERS; i++) begin
                cnt[i]       <= '0;
                counter_a[i] <= '0;
            end
            ovf_a      <= '0;
            bus.rd_ack <= 1'b0;
        end else begin
            bus.rd_ack <= rd_valid;
            for (int i = 0; i < N_COUNTERS; i++) begin
                if (rd_hit[i]) begin
                    counter_a[i] <= nxt[i];
                    if (CLR_ON_RD != 0) begin
                        cnt[i]   <= '0;
                        ovf_a[i] <= carry[i];
                    end else begin
                        cnt[i]   <= nxt[i];
                        ovf_a[i] <= ovf_a[i] | carry[i];
                    end
                end else if (wr_hit[i]) begin
                    cnt[i]   <= wres[i];
                    ovf_a[i] <= ovf_a[i] | carry[i] | borrow[i];
                end else begin
                    cnt[i]   <= nxt[i];
                    ovf_a[i] <= ovf_a[i] | carry[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_nx_event_counter_array_mp.sv
// Bench for nx_event_counter_array_mp: a saturating and a wrapping 8-bit instance
// share stimulus and are checked against a plain-arithmetic reference model.
module tb_nx_event_counter_array_mp;
    localparam int NC = 6, NP = 2, CB = 4, IDW = 3, NCB = 8, AB = 16, RB = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AB-1:0]           reg_addr;
    logic                    counter_config, rd_stb, wr_stb;
    logic [RB-1:0]           reg_data;
    logic [NP-1:0]           count_stb;
    logic [NP-1:0][CB-1:0]   count_by;
    logic [NP-1:0][IDW-1:0]  count_id;

    nx_event_counter_array_mp_if #(.N_ADDR_BITS(AB), .N_REG_BITS(RB), .N_PORTS(NP),
        .N_COUNT_BY_BITS(CB), .N_ID_BITS(IDW)) bus_s ();
    nx_event_counter_array_mp_if #(.N_ADDR_BITS(AB), .N_REG_BITS(RB), .N_PORTS(NP),
        .N_COUNT_BY_BITS(CB), .N_ID_BITS(IDW)) bus_w ();

    assign bus_s.reg_addr = reg_addr;        assign bus_w.reg_addr = reg_addr;
    assign bus_s.counter_config = counter_config; assign bus_w.counter_config = counter_config;
    assign bus_s.rd_stb = rd_stb;            assign bus_w.rd_stb = rd_stb;
    assign bus_s.wr_stb = wr_stb;            assign bus_w.wr_stb = wr_stb;
    assign bus_s.reg_data = reg_data;        assign bus_w.reg_data = reg_data;
    assign bus_s.count_stb = count_stb;      assign bus_w.count_stb = count_stb;
    assign bus_s.count_by = count_by;        assign bus_w.count_by = count_by;
    assign bus_s.count_id = count_id;        assign bus_w.count_id = count_id;

    logic [NCB-1:0] ca_s [NC];
    logic [NCB-1:0] ca_w [NC];
    logic [NC-1:0]  ovf_s, ovf_w;

    nx_event_counter_array_mp #(.N_COUNTERS(NC), .N_PORTS(NP), .N_COUNT_BY_BITS(CB),
        .N_COUNTER_BITS(NCB), .SATURATE(1), .CLR_ON_RD(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .counter_a(ca_s), .ovf_a(ovf_s));

    nx_event_counter_array_mp #(.N_COUNTERS(NC), .N_PORTS(NP), .N_COUNT_BY_BITS(CB),
        .N_COUNTER_BITS(NCB), .SATURATE(0), .CLR_ON_RD(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w), .counter_a(ca_w), .ovf_a(ovf_w));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: index 0 = saturating instance, 1 = wrapping instance.
    longint m_cnt  [2][NC];
    longint m_snap [2][NC];
    bit     m_ovf  [2][NC];
    bit     m_ack;

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NC; i++) begin
                m_cnt[k][i] = 0; m_snap[k][i] = 0; m_ovf[k][i] = 0;
            end
        m_ack = 0;
    endtask

    task automatic model_step();
        bit rdv, wrv, sel, c;
        int idx;
        longint v, d;
        sel = reg_addr < 24;
        idx = int'(reg_addr) / 4;
        rdv = counter_config ? (rd_stb && reg_addr == 0) : (rd_stb && sel);
        wrv = wr_stb && sel && !rdv;
        m_ack = rdv;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NC; i++) begin
                v = m_cnt[k][i];
                for (int p = 0; p < NP; p++)
                    if (count_stb[p] && int'(count_id[p]) == i) v += longint'(count_by[p]);
                c = v > 255;
                if (c) v = (k == 0) ? 255 : v - 256;
                if (rdv && (counter_config || idx == i)) begin
                    m_snap[k][i] = v; m_cnt[k][i] = 0; m_ovf[k][i] = c;
                end else if (wrv && idx == i) begin
                    d = v - longint'(reg_data);
                    if (d < 0) begin
                        d = (k == 0) ? 0 : ((d % 256) + 256) % 256;
                        m_ovf[k][i] = 1;
                    end
                    m_cnt[k][i] = d;
                    if (c) m_ovf[k][i] = 1;
                end else begin
                    m_cnt[k][i] = v;
                    if (c) m_ovf[k][i] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        count_stb = '0; count_by = '0; count_id = '0;
        rd_stb = 0; wr_stb = 0; counter_config = 0; reg_addr = '0; reg_data = '0;
    endtask

    task automatic do_read(input int addr);
        idle(); rd_stb = 1; reg_addr = AB'(addr); tick(); idle();
    endtask

    task automatic load(input int id, input int val);
        int b0, b1;
        do_read(id * 4);
        while (val > 0) begin
            b0 = (val > 15) ? 15 : val; val -= b0;
            b1 = (val > 15) ? 15 : val; val -= b1;
            idle();
            count_stb = {b1 != 0, 1'b1};
            count_by[0] = CB'(b0); count_id[0] = IDW'(id);
            count_by[1] = CB'(b1); count_id[1] = IDW'(id);
            tick();
        end
        idle();
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        count_stb = 2'b11; count_by[0] = 4'd9; count_by[1] = 4'd3; count_id[1] = 3'd2;
        rd_stb = 1; wr_stb = 1; reg_addr = 16'd4; reg_data = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        model_reset();
        rst_n = 1;
        #1;
        for (int i = 0; i < NC; i++) begin
            n_checks++;
            if (ca_s[i] !== 0 || ca_w[i] !== 0) begin
                n_fail++; $display("FAIL reset counter_a[%0d]: got %0d/%0d want 0", i, ca_s[i], ca_w[i]);
            end
        end
        n_checks++;
        if (ovf_s !== 0 || ovf_w !== 0 || bus_s.rd_ack !== 0 || bus_w.rd_ack !== 0) begin
            n_fail++; $display("FAIL reset flags: ovf %b/%b ack %b/%b want 0", ovf_s, ovf_w, bus_s.rd_ack, bus_w.rd_ack);
        end
        idle();
    endtask

    task automatic test_collision();
        do_read(12);
        for (int c = 0; c < 4; c++) begin
            idle(); count_stb = 2'b11;
            count_id[0] = 3'd3; count_by[0] = 4'd5;
            count_id[1] = 3'd3; count_by[1] = 4'd7;
            tick();
        end
        do_read(12);
        n_checks++;
        if (ca_s[3] !== 8'd48 || ca_w[3] !== 8'd48 || bus_s.rd_ack !== 1'b1) begin
            n_fail++; $display("FAIL collision sum: got %0d/%0d ack %b want 48 ack 1", ca_s[3], ca_w[3], bus_s.rd_ack);
        end
        do_read(12);
        n_checks++;
        if (ca_s[3] !== 8'd0) begin
            n_fail++; $display("FAIL collision clear: got %0d want 0", ca_s[3]);
        end
    endtask

    task automatic test_read_count();
        load(2, 10);
        idle(); rd_stb = 1; reg_addr = 16'd8;
        count_stb = 2'b01; count_id[0] = 3'd2; count_by[0] = 4'd3;
        tick(); idle();
        n_checks++;
        if (ca_s[2] !== 8'd13) begin
            n_fail++; $display("FAIL read_count same-cycle: got %0d want 13", ca_s[2]);
        end
        do_read(8);
        n_checks++;
        if (ca_s[2] !== 8'd0) begin
            n_fail++; $display("FAIL read_count no-loss: got %0d want 0", ca_s[2]);
        end
    endtask

    task automatic test_saturate();
        load(1, 250);
        n_checks++;
        if (ovf_s[1] !== 1'b0 || ovf_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL saturate pre-ovf: got %b/%b want 0", ovf_s[1], ovf_w[1]);
        end
        idle(); count_stb = 2'b01; count_id[0] = 3'd1; count_by[0] = 4'd15;
        tick(); idle();
        n_checks++;
        if (ovf_s[1] !== 1'b1 || ovf_w[1] !== 1'b1) begin
            n_fail++; $display("FAIL saturate ovf: got %b/%b want 1", ovf_s[1], ovf_w[1]);
        end
        do_read(4);
        n_checks++;
        if (ca_s[1] !== 8'd255 || ca_w[1] !== 8'd9) begin
            n_fail++; $display("FAIL saturate value: got %0d/%0d want 255/9", ca_s[1], ca_w[1]);
        end
        n_checks++;
        if (ovf_s[1] !== 1'b0 || ovf_w[1] !== 1'b0) begin
            n_fail++; $display("FAIL saturate ovf clear-on-read: got %b/%b want 0", ovf_s[1], ovf_w[1]);
        end
    endtask

    task automatic test_write();
        load(4, 100);
        idle(); wr_stb = 1; reg_addr = 16'd16; reg_data = 32'd30;
        count_stb = 2'b01; count_id[0] = 3'd4; count_by[0] = 4'd4;
        tick(); idle();
        do_read(16);
        n_checks++;
        if (ca_s[4] !== 8'd74 || ca_w[4] !== 8'd74) begin
            n_fail++; $display("FAIL write subtract: got %0d/%0d want 74", ca_s[4], ca_w[4]);
        end
        load(5, 5);
        idle(); wr_stb = 1; reg_addr = 16'd20; reg_data = 32'd200;
        tick(); idle();
        n_checks++;
        if (ovf_s[5] !== 1'b1 || ovf_w[5] !== 1'b1) begin
            n_fail++; $display("FAIL write borrow ovf: got %b/%b want 1", ovf_s[5], ovf_w[5]);
        end
        do_read(20);
        n_checks++;
        if (ca_s[5] !== 8'd0 || ca_w[5] !== 8'd61) begin
            n_fail++; $display("FAIL write borrow value: got %0d/%0d want 0/61", ca_s[5], ca_w[5]);
        end
    endtask

    task automatic test_global();
        load(0, 7); load(3, 40); load(5, 200);
        idle(); counter_config = 1; rd_stb = 1; reg_addr = 16'd0;
        count_stb = 2'b11; count_id[0] = 3'd3; count_by[0] = 4'd2;
        count_id[1] = 3'd6; count_by[1] = 4'd9;
        tick(); idle();
        n_checks++;
        if (ca_s[0] !== 8'd7 || ca_s[3] !== 8'd42 || ca_s[5] !== 8'd200 || bus_s.rd_ack !== 1'b1) begin
            n_fail++; $display("FAIL global snapshot: got %0d %0d %0d ack %b want 7 42 200 ack 1",
                               ca_s[0], ca_s[3], ca_s[5], bus_s.rd_ack);
        end
        idle(); counter_config = 1; rd_stb = 1; reg_addr = 16'd0;
        tick(); idle();
        for (int i = 0; i < NC; i++) begin
            n_checks++;
            if (ca_s[i] !== 8'd0 || ca_w[i] !== 8'd0) begin
                n_fail++; $display("FAIL global clear [%0d]: got %0d/%0d want 0", i, ca_s[i], ca_w[i]);
            end
        end
        load(2, 20);
        idle(); rd_stb = 1; wr_stb = 1; reg_addr = 16'd8; reg_data = 32'd5;
        tick(); idle();
        n_checks++;
        if (ca_s[2] !== 8'd20 || bus_s.rd_ack !== 1'b1) begin
            n_fail++; $display("FAIL rd_wr collision: got %0d ack %b want 20 ack 1", ca_s[2], bus_s.rd_ack);
        end
        idle(); counter_config = 1; rd_stb = 1; reg_addr = 16'd8;
        tick(); idle();
        n_checks++;
        if (bus_s.rd_ack !== 1'b0) begin
            n_fail++; $display("FAIL global non-matching addr ack: got %b want 0", bus_s.rd_ack);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                count_stb = 2'b11; rd_stb = 1;
                rst_n = 0; #2;
                model_reset();
                for (int i = 0; i < NC; i++) begin
                    n_checks++;
                    if (ca_s[i] !== 0 || ca_w[i] !== 0 || ovf_s !== 0 || bus_s.rd_ack !== 0) begin
                        n_fail++; $display("FAIL random mid-reset [%0d]: got %0d/%0d ovf %b want 0", i, ca_s[i], ca_w[i], ovf_s);
                    end
                end
                rst_n = 1;
            end
            counter_config = ($urandom_range(0, 9) < 3);
            rd_stb   = ($urandom_range(0, 9) < 2);
            wr_stb   = ($urandom_range(0, 9) < 2);
            reg_addr = AB'($urandom_range(0, 31));
            reg_data = RB'($urandom_range(0, 300));
            count_stb = NP'($urandom_range(0, 3));
            for (int p = 0; p < NP; p++) begin
                count_by[p] = CB'($urandom_range(0, 15));
                count_id[p] = IDW'($urandom_range(0, 7));
            end
            tick();
            n_checks++;
            if (bus_s.rd_ack !== m_ack || bus_w.rd_ack !== m_ack) begin
                n_fail++; $display("FAIL random rd_ack cyc %0d: got %b/%b want %b", n, bus_s.rd_ack, bus_w.rd_ack, m_ack);
            end
            for (int i = 0; i < NC; i++) begin
                n_checks++;
                if (ca_s[i] !== NCB'(m_snap[0][i]) || ca_w[i] !== NCB'(m_snap[1][i])
                    || ovf_s[i] !== m_ovf[0][i] || ovf_w[i] !== m_ovf[1][i]) begin
                    n_fail++;
                    $display("FAIL random [%0d] cyc %0d: got ca %0d/%0d ovf %b/%b want ca %0d/%0d ovf %b/%b",
                             i, n, ca_s[i], ca_w[i], ovf_s[i], ovf_w[i],
                             m_snap[0][i], m_snap[1][i], m_ovf[0][i], m_ovf[1][i]);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_collision();
        test_read_count();
        test_saturate();
        test_write();
        test_global();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
